// File: rtl/seg_mux_pkg.sv
// Shared constants for the multiplexed seven-segment driver.
// Segment patterns are logical active-high, ordered {g,f,e,d,c,b,a}.
package seg_mux_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] DIGIT_BLANK = 4'hF;

    localparam logic [6:0] SEG_OFF = 7'b0000000;
    localparam logic [6:0] SEG_0   = 7'b0111111;
    localparam logic [6:0] SEG_1   = 7'b0000110;
    localparam logic [6:0] SEG_2   = 7'b1011011;
    localparam logic [6:0] SEG_3   = 7'b1001111;
    localparam logic [6:0] SEG_4   = 7'b1100110;
    localparam logic [6:0] SEG_5   = 7'b1101101;
    localparam logic [6:0] SEG_6   = 7'b1111101;
    localparam logic [6:0] SEG_7   = 7'b0000111;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1101111;

endpackage

// File: rtl/seg_mux_driver_decode.sv
// BCD to seven-segment decoder, logical active-high.
// Codes 10..15 decode dark.
module seg7_decode
    import seg_mux_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [6:0]         seg
);

    always_comb begin
        seg = SEG_OFF;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_mux_driver.sv
// Time-multiplexed, double-buffered seven-segment driver.
// Define SEG_MUX_LZB_EN to enable leading-zero blanking.
module seg_mux_driver
    import seg_mux_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int SCAN_DIV       = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
    input  logic                          load,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    output logic [6:0]                    seg,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int WW = DIGIT_W * NUM_DIGITS;

    localparam logic [6:0]            SEG_INV = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_INV  = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [WW-1:0]         pending;
    logic [WW-1:0]         shadow;
    logic                  pend_valid;
    logic                  slot_end;
    logic                  frame_wrap;
    logic [NUM_DIGITS-1:0] lz_dark;
    logic [NUM_DIGITS-1:0] dark;
    logic [DIGIT_W-1:0]    cur_digit;
    logic                  cur_dark;
    logic [6:0]            dec_seg;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    assign slot_end   = (cnt == CW'(SCAN_DIV - 1));
    assign frame_wrap = slot_end && (idx == IW'(NUM_DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Shadow only changes at a frame boundary so a frame never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= {NUM_DIGITS{DIGIT_BLANK}};
            shadow     <= {NUM_DIGITS{DIGIT_BLANK}};
            pend_valid <= 1'b0;
        end else if (load && frame_wrap) begin
            shadow     <= digits_in;
            pending    <= digits_in;
            pend_valid <= 1'b0;
        end else begin
            if (frame_wrap && pend_valid) begin
                shadow     <= pending;
                pend_valid <= 1'b0;
            end
            if (load) begin
                pending    <= digits_in;
                pend_valid <= 1'b1;
            end
        end
    end

`ifdef SEG_MUX_LZB_EN
    logic lz_seen;

    always_comb begin
        lz_seen = 1'b0;
        lz_dark = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (shadow[i*DIGIT_W +: DIGIT_W] != '0) begin
                lz_seen = 1'b1;
            end
            lz_dark[i] = !lz_seen;
        end
    end
`else
    assign lz_dark = '0;
`endif

    assign dark = blank_mask | lz_dark;

    always_comb begin
        cur_digit = DIGIT_BLANK;
        cur_dark  = 1'b0;
        an_next   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_digit  = shadow[i*DIGIT_W +: DIGIT_W];
                cur_dark   = dark[i];
                an_next[i] = (cnt != '0);
            end
        end
    end

    seg7_decode u_dec (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

    // Slot cycle zero is dead-time between digits.
    always_comb begin
        seg_next = SEG_OFF;
        if (cnt != '0 && !cur_dark) begin
            seg_next = dec_seg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= SEG_OFF ^ SEG_INV;
            an         <= AN_INV;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_next ^ SEG_INV;
            an         <= an_next ^ AN_INV;
            frame_tick <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seg_mux_driver.sv
// Directed bench for seg_mux_driver, NUM_DIGITS=6, SCAN_DIV=4,
// with an active-low twin instance sharing the same inputs.
module tb_seg_mux_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] digits_in = '0;
    logic        load = 1'b0;
    logic [5:0]  blank_mask = '0;
    logic [6:0]  seg, seg_n;
    logic [5:0]  an, an_n;
    logic        frame_tick, frame_tick_n;

    int tests = 0;
    int fails = 0;

    logic [6:0] cap_seg [6];
    int         cap_lit [6];
    int         cap_dead, cap_bad, cap_on;

    seg_mux_driver #(
        .NUM_DIGITS(6), .SCAN_DIV(4),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .load(load),
        .blank_mask(blank_mask), .seg(seg), .an(an),
        .frame_tick(frame_tick)
    );

    seg_mux_driver #(
        .NUM_DIGITS(6), .SCAN_DIV(4),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut_n (
        .clk(clk), .rst(rst), .digits_in(digits_in), .load(load),
        .blank_mask(blank_mask), .seg(seg_n), .an(an_n),
        .frame_tick(frame_tick_n)
    );

    always #5 clk = ~clk;

    task automatic wait_frame();
        int n;
        n = 0;
        @(negedge clk);
        while (!frame_tick && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!frame_tick) begin
            tests++;
            fails++;
            $display("FAIL frame_tick_timeout got=%b want=1", frame_tick);
        end
    endtask

    task automatic do_load(input logic [23:0] v);
        digits_in = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic capture();
        for (int i = 0; i < 6; i++) begin
            cap_seg[i] = 'x;
            cap_lit[i] = 0;
        end
        cap_dead = 0;
        cap_bad = 0;
        cap_on = 0;
        repeat (24) begin
            @(negedge clk);
            if (an == 6'b0) begin
                if (seg == 7'b0) cap_dead++;
                else cap_bad++;
            end else if ($onehot(an)) begin
                for (int i = 0; i < 6; i++) begin
                    if (an[i]) begin
                        if (cap_lit[i] > 0 && seg !== cap_seg[i]) cap_bad++;
                        cap_lit[i]++;
                        cap_seg[i] = seg;
                    end
                end
                if (seg != 7'b0) cap_on++;
            end else begin
                cap_bad++;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (an !== 6'b0) begin
            fails++;
            $display("FAIL rst_dead_cycle an=%b want=000000", an);
        end
        @(negedge clk);
        tests++;
        if (an !== 6'b000001 || seg !== 7'b0) begin
            fails++;
            $display("FAIL rst_first_lit an=%b seg=%b want 000001/0000000", an, seg);
        end
        do_load(24'h888888);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        @(negedge clk);
        tests++;
        if (an !== 6'b0 || seg !== 7'b0 || frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid an=%b seg=%b ft=%b want all zero", an, seg, frame_tick);
        end
        tests++;
        if (an_n !== 6'b111111 || seg_n !== 7'b1111111) begin
            fails++;
            $display("FAIL rst_mid_low an=%b seg=%b want all ones", an_n, seg_n);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_frame();
        capture();
        tests++;
        if (cap_on !== 0) begin
            fails++;
            $display("FAIL rst_no_light lit_samples=%0d want=0", cap_on);
        end
        tests++;
        if (cap_dead !== 6 || cap_bad !== 0) begin
            fails++;
            $display("FAIL rst_scan dead=%0d bad=%0d want 6/0", cap_dead, cap_bad);
        end
    endtask

    task automatic test_decode();
        logic [6:0] exp_seg [6];
        exp_seg = '{7'b1111101, 7'b1101101, 7'b1100110,
                    7'b1001111, 7'b1011011, 7'b0000110};
        do_load(24'h123456);
        wait_frame();
        capture();
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (cap_seg[i] !== exp_seg[i] || cap_lit[i] !== 3) begin
                fails++;
                $display("FAIL decode_d%0d seg=%b lit=%0d want %b/3", i, cap_seg[i], cap_lit[i], exp_seg[i]);
            end
        end
        tests++;
        if (cap_dead !== 6 || cap_bad !== 0) begin
            fails++;
            $display("FAIL decode_scan dead=%0d bad=%0d want 6/0", cap_dead, cap_bad);
        end
    endtask

    task automatic test_last_wins();
        wait_frame();
        do_load(24'h111111);
        @(negedge clk);
        do_load(24'h222222);
        wait_frame();
        capture();
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (cap_seg[i] !== 7'b1011011) begin
                fails++;
                $display("FAIL last_wins_d%0d seg=%b want=1011011", i, cap_seg[i]);
            end
        end
    endtask

    task automatic test_wrap_load();
        wait_frame();
        repeat (4) @(negedge clk);
        do_load(24'h999999);
        repeat (18) @(negedge clk);
        digits_in = 24'h777777;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        tests++;
        if (frame_tick !== 1'b1) begin
            fails++;
            $display("FAIL wrap_align ft=%b want=1", frame_tick);
        end
        repeat (2) begin
            capture();
            for (int i = 0; i < 6; i++) begin
                tests++;
                if (cap_seg[i] !== 7'b0000111) begin
                    fails++;
                    $display("FAIL wrap_load_d%0d seg=%b want=0000111", i, cap_seg[i]);
                end
            end
        end
    endtask

    task automatic test_blank();
        logic [6:0] exp_seg [6];
        exp_seg = '{7'b0111111, 7'b1111111, 7'b1001111,
                    7'b0000000, 7'b0000000, 7'b1101111};
        do_load(24'h9AF380);
        wait_frame();
        capture();
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (cap_seg[i] !== exp_seg[i] || cap_lit[i] !== 3) begin
                fails++;
                $display("FAIL blank_code_d%0d seg=%b lit=%0d want %b/3", i, cap_seg[i], cap_lit[i], exp_seg[i]);
            end
        end
        blank_mask = 6'b000100;
        wait_frame();
        capture();
        exp_seg[2] = 7'b0000000;
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (cap_seg[i] !== exp_seg[i] || cap_lit[i] !== 3) begin
                fails++;
                $display("FAIL blank_mask_d%0d seg=%b lit=%0d want %b/3", i, cap_seg[i], cap_lit[i], exp_seg[i]);
            end
        end
        blank_mask = 6'b0;
    endtask

    task automatic test_lzb();
        logic [6:0] exp_a [6];
        logic [6:0] exp_b [6];
`ifdef SEG_MUX_LZB_EN
        exp_a = '{7'b1011011, 7'b1100110, 7'b0, 7'b0, 7'b0, 7'b0};
        exp_b = '{7'b0111111, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0};
`else
        exp_a = '{7'b1011011, 7'b1100110, 7'b0111111,
                  7'b0111111, 7'b0111111, 7'b0111111};
        exp_b = '{6{7'b0111111}};
`endif
        do_load(24'h000042);
        wait_frame();
        capture();
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (cap_seg[i] !== exp_a[i]) begin
                fails++;
                $display("FAIL lzb42_d%0d seg=%b want=%b", i, cap_seg[i], exp_a[i]);
            end
        end
        do_load(24'h000000);
        wait_frame();
        capture();
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (cap_seg[i] !== exp_b[i]) begin
                fails++;
                $display("FAIL lzb0_d%0d seg=%b want=%b", i, cap_seg[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_polarity();
        int lit_n;
        int bad_n;
        int period;
        do_load(24'h888888);
        wait_frame();
        wait_frame();
        lit_n = 0;
        bad_n = 0;
        repeat (24) begin
            @(negedge clk);
            if (an_n == 6'b111111) begin
                if (seg_n !== 7'b1111111) bad_n++;
            end else begin
                lit_n++;
                if (seg_n !== 7'b0000000) bad_n++;
            end
        end
        tests++;
        if (lit_n !== 18 || bad_n !== 0) begin
            fails++;
            $display("FAIL pol_digit8 lit=%0d bad=%0d want 18/0", lit_n, bad_n);
        end
        tests++;
        if (frame_tick_n !== 1'b1) begin
            fails++;
            $display("FAIL pol_tick_align ft=%b want=1", frame_tick_n);
        end
        period = 0;
        do begin
            @(negedge clk);
            period++;
        end while (!frame_tick_n && period < 100);
        tests++;
        if (period !== 24) begin
            fails++;
            $display("FAIL pol_tick_period got=%0d want=24", period);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_last_wins();
        test_wrap_load();
        test_blank();
        test_lzb();
        test_polarity();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
